// File: rtl/shared_fifo_pkg.sv
// Shared definitions for the 5-queue shared-buffer FIFO and its drain/merge stages:
// queue count, queue id type and the round-robin scan helper.
package shared_fifo_pkg;

    localparam int NQ = 5;

    typedef logic [2:0] qid_t;

    typedef struct packed {
        qid_t g;
        logic found;
    } rr_res_t;

    // First set bit of elig scanning last+1, last+2, ... modulo 5 (wrap 4 -> 0).
    function automatic rr_res_t rr_next(input qid_t last, input logic [4:0] elig);
        rr_res_t r;
        int      idx;
        qid_t    i3;
        r.g     = '0;
        r.found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            idx = int'(last) + k;
            if (idx >= 5) idx = idx - 5;
            i3 = idx[2:0];
            if (!r.found && elig[i3]) begin
                r.found = 1'b1;
                r.g     = i3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker: grants the first eligible queue after last.
// Shared by the drain arbiter and the upstream merge.
module rr_pick5
    import shared_fifo_pkg::*;
(
    input  logic [2:0] last,
    input  logic [4:0] elig,
    output logic [2:0] g,
    output logic       found
);

    rr_res_t res;

    always_comb begin
        res   = rr_next(last, elig);
        g     = res.g;
        found = res.found;
    end

endmodule

// File: rtl/shared_fifo_drain_arb.sv
// Drain stage for the shared-buffer FIFO: round-robin pop of one non-empty queue per
// cycle onto a registered valid/ready stream. Optional macro SHARED_DRAIN_STRICT0_EN.
module shared_fifo_drain_arb #(
    parameter int WID = 32,
    parameter int NQ  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              softreset,
    input  logic [NQ-1:0]     empty,
    input  logic [NQ*WID-1:0] din,
    output logic [NQ-1:0]     readout,
    output logic              vldout,
    input  logic              readyin,
    output logic [WID-1:0]    dout,
    output logic [2:0]        qid,
    output logic [15:0]       beats
);

    // Output handshake: a word transfers on a rising edge where vldout && readyin;
    // dout/qid are held while vldout && !readyin, and a new word may load in the
    // same cycle the current one is accepted.

    logic [WID-1:0] din_a [NQ];
    logic [4:0]     elig;
    logic [4:0]     rr_elig;
    logic [2:0]     last;
    logic [2:0]     rr_g;
    logic [2:0]     g;
    logic           rr_found;
    logic           any_elig;
    logic           accept;
    logic           load;

    for (genvar i = 0; i < NQ; i++) begin : g_din
        assign din_a[i] = din[i*WID +: WID];
    end

    assign elig = ~empty;

`ifdef SHARED_DRAIN_STRICT0_EN
    // Queue 0 bypasses the rotation; round-robin only among queues 1..4.
    assign rr_elig = elig & 5'b11110;
    assign g       = elig[0] ? 3'd0 : rr_g;
`else
    assign rr_elig = elig;
    assign g       = rr_g;
`endif

    rr_pick5 u_pick (
        .last  (last),
        .elig  (rr_elig),
        .g     (rr_g),
        .found (rr_found)
    );

    assign any_elig = rr_found | elig[0];
    assign accept   = vldout && readyin;
    // softreset wins over a pop in the same cycle.
    assign load     = (!vldout || readyin) && any_elig && !softreset;

    always_comb begin
        readout = '0;
        if (load) readout[g] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vldout <= 1'b0;
            dout   <= '0;
            qid    <= '0;
            beats  <= '0;
            last   <= 3'd4;
        end else if (softreset) begin
            vldout <= 1'b0;
            dout   <= '0;
            qid    <= '0;
            beats  <= '0;
            last   <= 3'd4;
        end else begin
            if (load) begin
                dout   <= din_a[g];
                qid    <= g;
                vldout <= 1'b1;
`ifdef SHARED_DRAIN_STRICT0_EN
                if (g != 3'd0) last <= g;
`else
                last   <= g;
`endif
            end else if (accept) begin
                vldout <= 1'b0;
            end
            if (accept) beats <= beats + 16'd1;
        end
    end

endmodule

// File: tb/tb_shared_fifo_drain_arb.sv
// Directed bench for shared_fifo_drain_arb: models the shared FIFO as per-queue
// word queues and checks pops, output words, ids and beat counts.
module tb_shared_fifo_drain_arb;

    localparam int WID = 32;
    localparam int NQ  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              softreset;
    logic [NQ-1:0]     empty;
    logic [NQ*WID-1:0] din;
    logic [NQ-1:0]     readout;
    logic              vldout;
    logic              readyin;
    logic [WID-1:0]    dout;
    logic [2:0]        qid;
    logic [15:0]       beats;

    logic [WID-1:0] fq [NQ][$];
    logic [NQ-1:0]  rd_cap;
    logic [4:0]     exp_rd;
    int             checks   = 0;
    int             failures = 0;

    shared_fifo_drain_arb #(.WID(WID), .NQ(NQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .softreset (softreset),
        .empty     (empty),
        .din       (din),
        .readout   (readout),
        .vldout    (vldout),
        .readyin   (readyin),
        .dout      (dout),
        .qid       (qid),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    task automatic drive_inputs();
        for (int i = 0; i < NQ; i++) begin
            empty[i]             = (fq[i].size() == 0);
            din[i*WID +: WID]    = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture the pop strobe just before the edge, then retire popped words.
    task automatic tick();
        #1;
        rd_cap = readout;
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++)
            if (rd_cap[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        drive_inputs();
    endtask

    initial begin
        rst       = 1'b1;
        softreset = 1'b0;
        readyin   = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset default: idle for 10 cycles.
        for (int n = 0; n < 10; n++) begin
            #1;
            check("reset_vldout", 32'(vldout), 32'd0);
            check("reset_readout", 32'(readout), 32'd0);
            check("reset_beats", 32'(beats), 32'd0);
            tick();
        end

        // Single queue: queue 2 holds A, B, C.
        fq[2].push_back(32'hA);
        fq[2].push_back(32'hB);
        fq[2].push_back(32'hC);
        readyin = 1'b1;
        drive_inputs();
        for (int n = 0; n < 3; n++) begin
            #1;
            check("single_readout", 32'(readout), 32'b00100);
            tick();
            check("single_vldout", 32'(vldout), 32'd1);
            check("single_dout", dout, 32'hA + n);
            check("single_qid", 32'(qid), 32'd2);
        end
        #1;
        check("single_idle_readout", 32'(readout), 32'd0);
        tick();
        check("single_beats", 32'(beats), 32'd3);
        check("single_vld_drop", 32'(vldout), 32'd0);

        // Idle softreset restores the pointer so queue 0 wins next.
        softreset = 1'b1;
        tick();
        softreset = 1'b0;
        check("sr_idle_beats", 32'(beats), 32'd0);

        // Fairness: every queue holds 4 words, value 'h100*q + k.
        for (int q = 0; q < NQ; q++)
            for (int k = 0; k < 4; k++)
                fq[q].push_back(32'h100 * q + k);
        drive_inputs();
        for (int n = 0; n < 10; n++) begin
            exp_rd = 5'b00001 << (n % 5);
            #1;
            check("fair_readout", 32'(readout), 32'(exp_rd));
            tick();
            check("fair_dout", dout, 32'h100 * (n % 5) + (n / 5));
            check("fair_qid", 32'(qid), 32'(n % 5));
        end
        for (int q = 0; q < NQ; q++)
            check("fair_remaining", 32'(fq[q].size()), 32'd2);

        // Backpressure: word 'h401 from queue 4 must be held.
        readyin = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("bp_readout", 32'(readout), 32'd0);
            check("bp_dout", dout, 32'h401);
            check("bp_qid", 32'(qid), 32'd4);
            check("bp_vldout", 32'(vldout), 32'd1);
            tick();
        end
        readyin = 1'b1;
        #1;
        check("bp_resume_readout", 32'(readout), 32'b00001);
        tick();
        check("bp_resume_dout", dout, 32'h002);
        check("bp_resume_qid", 32'(qid), 32'd0);
        check("bp_beats", 32'(beats), 32'd10);

        // Softreset mid-stream: no pop, word dropped, pointer back to 4.
        softreset = 1'b1;
        #1;
        check("sr_readout", 32'(readout), 32'd0);
        tick();
        softreset = 1'b0;
        check("sr_vldout", 32'(vldout), 32'd0);
        check("sr_beats", 32'(beats), 32'd0);
        check("sr_q0_kept", 32'(fq[0].size()), 32'd1);
        #1;
        check("sr_first_grant", 32'(readout), 32'b00001);
        tick();
        check("sr_first_dout", dout, 32'h003);
        check("sr_first_qid", 32'(qid), 32'd0);
        #1;
        check("sr_second_grant", 32'(readout), 32'b00010);
        tick();
        check("sr_second_dout", dout, 32'h102);
        check("sr_beats_after", 32'(beats), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_fifo_drain_arb.md
# shared_fifo_drain_arb

Downstream drain stage for the 5-queue shared-buffer FIFO. It watches the five per-queue `empty` flags and show-ahead data words and picks at most one non-empty queue per cycle by round-robin. It pops the chosen queue with a one-hot `readout` and presents the word, tagged with its queue id, on a single registered valid/ready output stream toward the consumer.

## Interface
Parameters:
- `WID`, 32, data word width; must match the shared FIFO's `WID`.
- `NQ`, 5, number of source queues; fixed at 5 for this revision.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `softreset`  input  1  synchronous clear; same effect as `rst`, applied at the clock edge.
- `empty`  input  5  per-queue empty flags from the shared FIFO.
- `din`  input  5×WID  per-queue show-ahead data (`din[i]` is valid whenever `!empty[i]`).
- `readout`  output  5  one-hot or zero pop strobe to the shared FIFO.
- `vldout`  output  1  output word valid.
- `readyin`  input  1  consumer accepts the word when `vldout && readyin`.
- `dout`  output  WID  output data.
- `qid`  output  3  source queue of `dout` (0..4).
- `beats`  output  16  count of words accepted by the consumer.

## Operation
Output register:
- `load = (!vldout || readyin) && |elig`, where `elig = ~empty`, masked as described under Configuration.
- On `load`: `dout <= din[g]`, `qid <= g`, `vldout <= 1`.
- If `vldout && readyin && !load`: `vldout <= 0`.

Readout:
- `readout[g] = load`, combinational.
- `readout` is never asserted for an empty queue.
- `readout` never has more than one bit set.

Arbiter:
- 3-bit pointer `last`, range 0..4.
- Grant `g` is the first eligible queue scanning `last+1, last+2, …` modulo 5. The wrap goes 4→0, never through values 5..7.
- On `load`: `last <= g`.

Stall and idle:
- If no queue is eligible: `readout = 0`, `last` is unchanged, and `vldout` drops after the pending word is accepted.
- If `vldout && !readyin`: `dout`/`qid` are held, `readout = 0`, and `last` is unchanged.

Beat counter:
- `beats` increments on each `vldout && readyin`.
- It wraps 16'hFFFF→0.

Reset and softreset:
- `vldout=0`, `dout=0`, `qid=0`, `beats=0`, `last=4` (so queue 0 wins first).
- `softreset` has priority over `load` in the same cycle: no pop occurs (`readout` forced to 0) and the in-flight word is discarded.

## Timing
- Readout-to-output latency: 1 cycle. `readout[i]` in cycle N gives `vldout=1` with `dout=din[i]` from cycle N+1.
- Throughput: 1 word/cycle while `readyin=1` and any queue is non-empty. Back-to-back pops are allowed because a load occurs in the same cycle the current word is accepted.
- Combinational paths:
  - `readyin` → `readout`.
  - `empty` → `readout`.
  - `readyin` → `vldout`, `dout` or `qid`: none (all registered).
- `rst` takes effect asynchronously. Its release is synchronous to `clk`.

## Configuration
- `SHARED_DRAIN_STRICT0_EN` defined:
  - Queue 0 has strict priority. Whenever `!empty[0]` and a load occurs, `g=0`.
  - Round-robin applies only among queues 1..4.
  - `last` tracks the last grant from 1..4 only; a queue-0 grant leaves it unchanged.
  - Reset value of `last` is 4.
- Not defined: pure 5-way round-robin as described under Operation.

## Structure
- Shared package `shared_fifo_pkg` holds:
  - `localparam NQ = 5`.
  - `typedef logic [2:0] qid_t`.
  - The function `rr_next(qid_t last, logic [4:0] elig)`, returning the grant index and a found flag.
- One sub-module `rr_pick5` (combinational round-robin picker: `last`, `elig` → `g`, `found`), so the arbiter can be verified stand-alone and reused for the upstream merge.

## Test plan
- **Reset default:** release `rst`, all `empty=1` → `vldout=0`, `readout=0`, `beats=0` for 10 cycles.
- **Single queue:** queue 2 holds 3 words (0xA,0xB,0xC), `readyin=1` → `readout=5'b00100` for 3 consecutive cycles. `dout` = A,B,C with `qid=2` on cycles N+1..N+3, then `beats=3`.
- **Fairness:** all queues non-empty with ≥4 words, `readyin=1` → grant order 0,1,2,3,4,0,1,… Each queue gets exactly 2 of the first 10 pops.
- **Backpressure:** `readyin=0` for 5 cycles while `vldout=1` → `readout=0` and `dout`/`qid` stable. Reassert `readyin` → next pop in the same cycle, no word lost or duplicated.
- **Softreset mid-stream:** `softreset=1` while `vldout=1` and queues are non-empty → `readout=0` that cycle. Next cycle `vldout=0`, `beats=0`, and the first grant after release is queue 0.
- **Strict priority (with `SHARED_DRAIN_STRICT0_EN`):** queues 0 and 3 non-empty → queue 0 drains completely before queue 3 gets `readout`.
